mem_ctrl: RTL and testbench

- Memory controller downstream of dcache and icache; sole owner of the 8-bit RAM/IO bus.
- Accepts one-cycle request pulses from both clients, latches them, and arbitrates with data over instruction.
- Serialises each request into byte accesses, little-endian.
- Returns a one-cycle done pulse with assembled data to the requesting client.

---
 rtl/mem_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_mem_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// Memory controller: latches dcache/icache requests, data has priority, and serialises them into little-endian byte accesses on the 8-bit RAM/IO bus.
// Optional feature macro: MC_IO_LOAD_SINGLE_EN (I/O-region loads issue a single byte access).
module mem_ctrl #(
    parameter int ADDR_W    = 32,
    parameter int IO_SEL_HI = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              iIC_en,
    input  logic [ADDR_W-1:0] iIC_pc,
    output logic              oIC_done,
    output logic [31:0]       oIC_inst,
    input  logic              iDC_en,
    input  logic              iDC_ls,
    input  logic [ADDR_W-1:0] iDC_pc,
    input  logic [31:0]       iDC_dt,
    input  logic [2:0]        iDC_len,
    output logic              oDC_done,
    output logic [31:0]       oDC_dt,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);

    typedef enum logic [1:0] {IDLE, FETCH, LOAD, STORE} state_t;

    state_t            state_reg;
    logic              ic_pend_reg, dc_pend_reg;
    logic [ADDR_W-1:0] ic_addr_reg, dc_addr_reg, mem_a_reg;
    logic              dc_ls_reg;
    logic [31:0]       dc_dt_reg;
    logic [2:0]        dc_len_reg;
    logic [2:0]        cnt_reg, n_reg, cnt_next, dc_n;
    logic [31:0]       data_reg, data_next, ic_inst_reg, dc_out_reg;
    logic [7:0]        mem_dout_reg, din_hold_reg, din_eff, store_byte;
    logic              wr_reg, ic_done_reg, dc_done_reg, frz_reg;
    logic              a_is_io, store_stall;

    assign cnt_next    = cnt_reg + 3'd1;
    assign a_is_io     = mem_a_reg[IO_SEL_HI] & mem_a_reg[IO_SEL_HI-1];
    assign store_stall = (state_reg == STORE) && io_buffer_full && a_is_io;

    // The bus keeps running while rdy is low, so the byte that was valid when
    // the freeze began is held and substituted in the first resumed cycle.
    assign din_eff = frz_reg ? din_hold_reg : mem_din;

    always_ff @(posedge clk) begin
        if (rst) begin
            frz_reg      <= 1'b0;
            din_hold_reg <= 8'd0;
        end else begin
            frz_reg <= !rdy;
            if (!rdy && !frz_reg)
                din_hold_reg <= mem_din;
        end
    end

    always_comb begin
        dc_n = ((dc_len_reg == 3'd1) || (dc_len_reg == 3'd2) || (dc_len_reg == 3'd4))
               ? dc_len_reg : 3'd4;
`ifdef MC_IO_LOAD_SINGLE_EN
        if (!dc_ls_reg && dc_addr_reg[IO_SEL_HI] && dc_addr_reg[IO_SEL_HI-1])
            dc_n = 3'd1;
`endif
    end

    always_comb begin
        case (cnt_next[1:0])
            2'd0:    store_byte = dc_dt_reg[7:0];
            2'd1:    store_byte = dc_dt_reg[15:8];
            2'd2:    store_byte = dc_dt_reg[23:16];
            default: store_byte = dc_dt_reg[31:24];
        endcase
    end

    // Byte k-1 of the assembled word is filled while cnt == k.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign data_next[8*gi +: 8] = (cnt_reg == 3'(gi + 1)) ? din_eff : data_reg[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            ic_pend_reg  <= 1'b0;
            dc_pend_reg  <= 1'b0;
            ic_addr_reg  <= '0;
            dc_addr_reg  <= '0;
            dc_ls_reg    <= 1'b0;
            dc_dt_reg    <= 32'd0;
            dc_len_reg   <= 3'd0;
            cnt_reg      <= 3'd0;
            n_reg        <= 3'd0;
            data_reg     <= 32'd0;
            ic_inst_reg  <= 32'd0;
            dc_out_reg   <= 32'd0;
            mem_a_reg    <= '0;
            mem_dout_reg <= 8'd0;
            wr_reg       <= 1'b0;
            ic_done_reg  <= 1'b0;
            dc_done_reg  <= 1'b0;
        end else if (rdy) begin
            ic_done_reg <= 1'b0;
            dc_done_reg <= 1'b0;
            if (iIC_en && !ic_pend_reg) begin
                ic_pend_reg <= 1'b1;
                ic_addr_reg <= iIC_pc;
            end
            if (iDC_en && !dc_pend_reg) begin
                dc_pend_reg <= 1'b1;
                dc_ls_reg   <= iDC_ls;
                dc_addr_reg <= iDC_pc;
                dc_dt_reg   <= iDC_dt;
                dc_len_reg  <= iDC_len;
            end
            case (state_reg)
                IDLE: begin
                    cnt_reg  <= 3'd0;
                    data_reg <= 32'd0;
                    if (dc_pend_reg) begin
                        mem_a_reg    <= dc_addr_reg;
                        mem_dout_reg <= dc_dt_reg[7:0];
                        n_reg        <= dc_n;
                        wr_reg       <= dc_ls_reg;
                        state_reg    <= dc_ls_reg ? STORE : LOAD;
                    end else if (ic_pend_reg) begin
                        mem_a_reg <= ic_addr_reg;
                        n_reg     <= 3'd4;
                        wr_reg    <= 1'b0;
                        state_reg <= FETCH;
                    end
                end
                FETCH, LOAD: begin
                    data_reg <= data_next;
                    if (cnt_reg == n_reg) begin
                        state_reg <= IDLE;
                        if (state_reg == FETCH) begin
                            ic_done_reg <= 1'b1;
                            ic_inst_reg <= data_next;
                            ic_pend_reg <= 1'b0;
                        end else begin
                            dc_done_reg <= 1'b1;
                            dc_out_reg  <= data_next;
                            dc_pend_reg <= 1'b0;
                        end
                    end else begin
                        cnt_reg <= cnt_next;
                        if (cnt_next < n_reg)
                            mem_a_reg <= mem_a_reg + 1'b1;
                    end
                end
                STORE: begin
                    if (!store_stall) begin
                        if (cnt_next == n_reg) begin
                            wr_reg      <= 1'b0;
                            dc_done_reg <= 1'b1;
                            dc_pend_reg <= 1'b0;
                            state_reg   <= IDLE;
                        end else begin
                            cnt_reg      <= cnt_next;
                            mem_a_reg    <= mem_a_reg + 1'b1;
                            mem_dout_reg <= store_byte;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign oIC_done = ic_done_reg;
    assign oIC_inst = ic_inst_reg;
    assign oDC_done = dc_done_reg;
    assign oDC_dt   = dc_out_reg;
    assign mem_a    = mem_a_reg;
    assign mem_dout = mem_dout_reg;
    assign mem_wr   = wr_reg & rdy & ~store_stall;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: stimulus pushes expected done/write events with their cycle numbers; a monitor pops and compares.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        iIC_en, iDC_en, iDC_ls;
    logic [31:0] iIC_pc, iDC_pc, iDC_dt;
    logic [2:0]  iDC_len;
    logic        oIC_done, oDC_done, mem_wr;
    logic [31:0] oIC_inst, oDC_dt, mem_a;
    logic [7:0]  mem_din, mem_dout;
    logic        io_buffer_full;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct { int cyc; logic [31:0] data; logic chk; } done_t;
    typedef struct { int cyc; logic [31:0] a; logic [7:0] d; } wr_t;
    done_t dc_q[$];
    done_t ic_q[$];
    wr_t   wr_q[$];
    done_t dc_e, ic_e;
    wr_t   wr_e;

    logic [7:0] mem [logic [31:0]];

    mem_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .iIC_en(iIC_en), .iIC_pc(iIC_pc), .oIC_done(oIC_done), .oIC_inst(oIC_inst),
        .iDC_en(iDC_en), .iDC_ls(iDC_ls), .iDC_pc(iDC_pc), .iDC_dt(iDC_dt), .iDC_len(iDC_len),
        .oDC_done(oDC_done), .oDC_dt(oDC_dt),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0] ^ 8'h5A;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_wr) mem[mem_a] = mem_dout;
        mem_din <= rd(mem_a);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%08h required=%08h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (oDC_done) begin
                if (dc_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL dc_done_unexpected actual=1 required=0 (cyc %0d)", cyc);
                end else begin
                    dc_e = dc_q.pop_front();
                    check("dc_done_cycle", 32'(cyc), 32'(dc_e.cyc));
                    if (dc_e.chk) check("dc_data", oDC_dt, dc_e.data);
                    $display("DC done cyc=%0d dt=%08h", cyc, oDC_dt);
                end
            end
            if (oIC_done) begin
                if (ic_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL ic_done_unexpected actual=1 required=0 (cyc %0d)", cyc);
                end else begin
                    ic_e = ic_q.pop_front();
                    check("ic_done_cycle", 32'(cyc), 32'(ic_e.cyc));
                    check("ic_inst", oIC_inst, ic_e.data);
                    $display("IC done cyc=%0d inst=%08h", cyc, oIC_inst);
                end
            end
            if (mem_wr) begin
                if (wr_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL wr_unexpected actual=1 required=0 (cyc %0d a=%08h)", cyc, mem_a);
                end else begin
                    wr_e = wr_q.pop_front();
                    check("wr_cycle", 32'(cyc), 32'(wr_e.cyc));
                    check("wr_addr", mem_a, wr_e.a);
                    check("wr_data", {24'd0, mem_dout}, {24'd0, wr_e.d});
                    $display("WR cyc=%0d a=%08h d=%02h", cyc, mem_a, mem_dout);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic dc_req(input logic ls, input logic [31:0] pc, input logic [31:0] dt,
                          input logic [2:0] len, output int t);
        iDC_en = 1'b1; iDC_ls = ls; iDC_pc = pc; iDC_dt = dt; iDC_len = len;
        t = cyc;
        tick(1);
        iDC_en = 1'b0;
    endtask

    task automatic push_dc(input int c, input logic [31:0] d, input logic chk);
        done_t e;
        e.cyc = c; e.data = d; e.chk = chk;
        dc_q.push_back(e);
    endtask

    task automatic push_wr(input int c, input logic [31:0] a, input logic [7:0] d);
        wr_t e;
        e.cyc = c; e.a = a; e.d = d;
        wr_q.push_back(e);
    endtask

    initial begin
        int t;
        done_t ie;
        rst = 1'b1; rdy = 1'b1; iIC_en = 1'b0; iDC_en = 1'b0; iDC_ls = 1'b0;
        iIC_pc = 32'd0; iDC_pc = 32'd0; iDC_dt = 32'd0; iDC_len = 3'd0; io_buffer_full = 1'b0;
        mem[32'h100] = 8'h11; mem[32'h101] = 8'h22; mem[32'h102] = 8'h33; mem[32'h103] = 8'h44;
        mem[32'h10] = 8'hA5; mem[32'h11] = 8'h5A;
        mem[32'h0] = 8'h01; mem[32'h1] = 8'h02; mem[32'h2] = 8'h03; mem[32'h3] = 8'h04;

        @(posedge clk); @(negedge clk);
        check("rst_oIC_done", {31'd0, oIC_done}, 32'd0);
        check("rst_oIC_inst", oIC_inst, 32'd0);
        check("rst_oDC_done", {31'd0, oDC_done}, 32'd0);
        check("rst_oDC_dt", oDC_dt, 32'd0);
        check("rst_mem_a", mem_a, 32'd0);
        check("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
        check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        tick(1);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_mem_wr", {31'd0, mem_wr}, 32'd0);
        end
        tick(1);

        // load len 4; a second pulse while in service must be dropped
        dc_req(1'b0, 32'h100, 32'd0, 3'd4, t);
        push_dc(t + 7, 32'h44332211, 1'b1);
        tick(2);
        dc_req(1'b0, 32'h500, 32'd0, 3'd1, t);
        tick(10);

        dc_req(1'b1, 32'h200, 32'hAABBCCDD, 3'd1, t);
        push_wr(t + 2, 32'h200, 8'hDD);
        push_dc(t + 3, 32'd0, 1'b0);
        tick(6);

        // simultaneous fetch and load: data first
        iIC_en = 1'b1; iIC_pc = 32'h0;
        dc_req(1'b0, 32'h10, 32'd0, 3'd2, t);
        iIC_en = 1'b0;
        push_dc(t + 5, 32'h00005AA5, 1'b1);
        ie.cyc = t + 11; ie.data = 32'h04030201; ie.chk = 1'b1;
        ic_q.push_back(ie);
        tick(14);

        // store wrapping past the top of the address space, then read it back
        dc_req(1'b1, 32'hFFFFFFFE, 32'h12345678, 3'd4, t);
        push_wr(t + 2, 32'hFFFFFFFE, 8'h78);
        push_wr(t + 3, 32'hFFFFFFFF, 8'h56);
        push_wr(t + 4, 32'h00000000, 8'h34);
        push_wr(t + 5, 32'h00000001, 8'h12);
        push_dc(t + 6, 32'd0, 1'b0);
        tick(8);
        dc_req(1'b0, 32'hFFFFFFFE, 32'd0, 3'd4, t);
        push_dc(t + 7, 32'h12345678, 1'b1);
        tick(10);

        // I/O store held off by a full write buffer for 5 cycles
        io_buffer_full = 1'b1;
        dc_req(1'b1, 32'h00030000, 32'h00000077, 3'd1, t);
        push_wr(t + 7, 32'h00030000, 8'h77);
        push_dc(t + 8, 32'd0, 1'b0);
        tick(6);
        io_buffer_full = 1'b0;
        tick(4);

        // rdy low for 3 cycles in the middle of a load
        dc_req(1'b0, 32'h100, 32'd0, 3'd4, t);
        push_dc(t + 10, 32'h44332211, 1'b1);
        tick(2);
        rdy = 1'b0;
        tick(3);
        rdy = 1'b1;
        tick(8);

        // rdy low during a store: writes must be suppressed, then resume
        dc_req(1'b1, 32'h300, 32'h0000BEEF, 3'd2, t);
        push_wr(t + 4, 32'h300, 8'hEF);
        push_wr(t + 5, 32'h301, 8'hBE);
        push_dc(t + 6, 32'd0, 1'b0);
        tick(1);
        rdy = 1'b0;
        tick(2);
        rdy = 1'b1;
        tick(6);

        // I/O load of 2 bytes
        dc_req(1'b0, 32'h00030010, 32'd0, 3'd2, t);
`ifdef MC_IO_LOAD_SINGLE_EN
        push_dc(t + 4, 32'h0000004A, 1'b1);
`else
        push_dc(t + 5, 32'h00004B4A, 1'b1);
`endif
        tick(8);

        // reset in mid-load: no done, outputs cleared, recovery afterwards
        dc_req(1'b0, 32'h100, 32'd0, 3'd4, t);
        tick(2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_oDC_dt", oDC_dt, 32'd0);
        check("midrst_mem_a", mem_a, 32'd0);
        tick(10);
        iIC_en = 1'b1; iIC_pc = 32'h100;
        t = cyc;
        tick(1);
        iIC_en = 1'b0;
        ie.cyc = t + 7; ie.data = 32'h44332211; ie.chk = 1'b1;
        ic_q.push_back(ie);

        for (int i = 0; i < 100 && (dc_q.size() + ic_q.size() + wr_q.size()) != 0; i++)
            tick(1);
        tick(5);
        check("queues_drained", 32'(dc_q.size() + ic_q.size() + wr_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
